// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with programmable modulus, prescaler, parallel load,
// wrap/saturate mode, registered terminal-count pulse and sticky wrapped flag.
module mod_updown_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned PRESCALE  = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_wrap_clr,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrapped,
  output logic             o_at_max,
  output logic             o_at_min
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PreLast = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_pcnt;
  logic             r_tc;
  logic             r_wrapped;

  logic             w_step;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_hit;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_load_clip;

  always_comb begin
    w_step      = i_en && (r_pcnt == PreLast);
    w_at_max    = (r_q == MaxVal);
    w_at_min    = (r_q == '0);
    w_hit       = w_step && (i_up ? w_at_max : w_at_min);
    w_load_clip = (i_load_val > MaxVal) ? MaxVal : i_load_val;
    w_q_step    = r_q;
    // Range ends compare against MaxVal, so non-power-of-2 moduli wrap correctly.
    if (i_up) begin
      if (!w_at_max)      w_q_step = r_q + WIDTH'(1);
      else if (!SATURATE) w_q_step = '0;
    end else begin
      if (!w_at_min)      w_q_step = r_q - WIDTH'(1);
      else if (!SATURATE) w_q_step = MaxVal;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q       <= '0;
      r_pcnt    <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (i_load) begin
      r_q       <= w_load_clip;
      r_pcnt    <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= r_wrapped & ~i_wrap_clr;
    end else begin
      r_tc      <= w_hit;
      r_wrapped <= w_hit | (r_wrapped & ~i_wrap_clr);
      if (i_en) begin
        r_pcnt <= w_step ? '0 : r_pcnt + PW'(1);
      end
      if (w_step) begin
        r_q <= w_q_step;
      end
    end
  end

  assign o_q       = r_q;
  assign o_tc      = r_tc;
  assign o_wrapped = r_wrapped;
  assign o_at_max  = w_at_max;
  assign o_at_min  = w_at_min;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations (wrap, saturate, prescale-3) share stimulus
// and are compared every cycle against a behavioural model, plus vector table and corner sequences.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load, wrap_clr;
  logic [3:0] load_val;
  logic [3:0] q [3];
  logic       tc [3], wr [3], amax [3], amin [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 = wrap, 1 = saturate, 2 = prescale 3
  int unsigned m_q [3], m_pc [3];
  bit          m_tc [3], m_wr [3];
  int unsigned m_pre [3] = '{1, 1, 3};
  bit          m_sat [3] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned MaxC = 9;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load), .i_load_val(load_val),
    .i_wrap_clr(wrap_clr), .o_q(q[0]), .o_tc(tc[0]), .o_wrapped(wr[0]), .o_at_max(amax[0]),
    .o_at_min(amin[0]));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load), .i_load_val(load_val),
    .i_wrap_clr(wrap_clr), .o_q(q[1]), .o_tc(tc[1]), .o_wrapped(wr[1]), .o_at_max(amax[1]),
    .o_at_min(amin[1]));

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .SATURATE(1'b0)) u_pre (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load), .i_load_val(load_val),
    .i_wrap_clr(wrap_clr), .o_q(q[2]), .o_tc(tc[2]), .o_wrapped(wr[2]), .o_at_max(amax[2]),
    .o_at_min(amin[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 0; m_pc[i] = 0; m_tc[i] = 0; m_wr[i] = 0;
    end
  endtask

  // Behavioural rules: load beats step; a step happens every PRESCALE-th enabled cycle.
  task automatic model_step();
    bit hit;
    for (int i = 0; i < 3; i++) begin
      if (load) begin
        m_q[i]  = (load_val > MaxC) ? MaxC : int'(load_val);
        m_pc[i] = 0;
        m_tc[i] = 0;
        if (wrap_clr) m_wr[i] = 0;
      end else begin
        hit = 0;
        if (en) begin
          m_pc[i]++;
          if (m_pc[i] == m_pre[i]) begin
            m_pc[i] = 0;
            if (up) begin
              if (m_q[i] == MaxC) begin hit = 1; if (!m_sat[i]) m_q[i] = 0; end
              else m_q[i]++;
            end else begin
              if (m_q[i] == 0) begin hit = 1; if (!m_sat[i]) m_q[i] = MaxC; end
              else m_q[i]--;
            end
          end
        end
        m_tc[i] = hit;
        if (hit) m_wr[i] = 1;
        else if (wrap_clr) m_wr[i] = 0;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model inst%0d {q,tc,wr,max,min}", i),
            {24'd0, q[i], tc[i], wr[i], amax[i], amin[i]},
            {24'd0, 4'(m_q[i]), m_tc[i], m_wr[i], m_q[i] == MaxC, m_q[i] == 0});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input bit e, input bit u, input bit l, input logic [3:0] lv, input bit c);
    en = e; up = u; load = l; load_val = lv; wrap_clr = c;
  endtask

  typedef struct {
    bit         en, up, load, clr;
    logic [3:0] lv;
    logic [3:0] eq;
    bit         etc, ewr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{en:0, up:1, load:1, clr:0, lv:4'd8,  eq:4'd8, etc:0, ewr:0};
    vecs[1] = '{en:1, up:1, load:0, clr:0, lv:4'd0,  eq:4'd9, etc:0, ewr:0};
    vecs[2] = '{en:1, up:1, load:0, clr:0, lv:4'd0,  eq:4'd0, etc:1, ewr:1};
    vecs[3] = '{en:0, up:1, load:0, clr:0, lv:4'd0,  eq:4'd0, etc:0, ewr:1};
    vecs[4] = '{en:1, up:0, load:0, clr:1, lv:4'd0,  eq:4'd9, etc:1, ewr:1};
    vecs[5] = '{en:0, up:0, load:0, clr:1, lv:4'd0,  eq:4'd9, etc:0, ewr:0};
    vecs[6] = '{en:1, up:1, load:1, clr:0, lv:4'd14, eq:4'd9, etc:0, ewr:0};
    vecs[7] = '{en:1, up:0, load:0, clr:0, lv:4'd0,  eq:4'd8, etc:0, ewr:0};
    vecs[8] = '{en:0, up:1, load:0, clr:0, lv:4'd0,  eq:4'd8, etc:0, ewr:0};

    set_in(0, 1, 0, 4'd0, 0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset state", {q[0], tc[0], wr[0], amin[0]}, {4'd0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv, vecs[i].clr);
      cycle();
      check($sformatf("vector %0d {q,tc,wr}", i), {q[0], tc[0], wr[0]},
            {vecs[i].eq, vecs[i].etc, vecs[i].ewr});
    end

    // Asynchronous reset mid-count with q=9, tc=1, wrapped=1
    set_in(0, 0, 1, 4'd0, 0); cycle();
    set_in(1, 0, 0, 4'd0, 0); cycle();
    set_in(0, 0, 0, 4'd0, 0);
    #2; rst_n = 1'b0; model_reset();
    #1;
    check("async reset", {q[0], tc[0], wr[0]}, {4'd0, 1'b0, 1'b0});
    #2; rst_n = 1'b1;

    // Count up 0..9 and wrap
    set_in(1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 10; i++) cycle();
    check("wrap up tc", {q[0], tc[0], wr[0]}, {4'd0, 1'b1, 1'b1});

    // Saturating down from 2
    set_in(0, 0, 1, 4'd2, 1); cycle();
    set_in(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("sat down step %0d", i), {q[1], tc[1]},
            {(i == 0) ? 4'd1 : 4'd0, i >= 2});
    end

    // Prescaler with enable pattern 1,1,0,1
    set_in(0, 1, 1, 4'd0, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(i != 2, 1, 0, 4'd0, 0);
      cycle();
      check($sformatf("prescale cycle %0d", i), q[2], (i == 3) ? 4'd1 : 4'd0);
    end

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
